// File: rtl/sfft_bin_streamer.sv
// sfft_bin_streamer: captures an SFFT output frame and streams its lower bins
// over valid/ready while tracking the largest-magnitude bin of each frame.
`ifndef NFFT
`define NFFT 8
`endif
`ifndef nFFT
`define nFFT 3
`endif
`ifndef SFFT_OUTPUT_WIDTH
`define SFFT_OUTPUT_WIDTH 16
`endif

module sfft_bin_streamer #(
    parameter int NFFT     = `NFFT,
    parameter int NUM_BINS = `NFFT / 2,
    parameter int W        = `SFFT_OUTPUT_WIDTH,
    parameter int IW       = `nFFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NFFT-1:0][W-1:0]   SFFT_Out,
    input  logic                     OutputValid,
    output logic [W-1:0]             bin_data,
    output logic [IW-1:0]            bin_index,
    output logic                     bin_valid,
    input  logic                     bin_ready,
    output logic                     bin_first,
    output logic                     bin_last,
    output logic [IW-1:0]            peak_index,
    output logic [W-1:0]             peak_mag,
    output logic                     peak_valid,
    output logic [15:0]              frames_dropped
);

    localparam int AW = $clog2(NUM_BINS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  frame [NUM_BINS];
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_inc;
    logic [W-1:0]  run_mag;
    logic [IW-1:0] run_idx;
    logic [W-1:0]  cur_mag;
    logic          take;
    logic [W-1:0]  nxt_mag;
    logic [IW-1:0] nxt_idx;
    logic          xfer;
    logic          accept;
    logic          busy_hit;

    // Bins above NUM_BINS mirror the lower half for real input; never read.
    generate
        if (NUM_BINS < NFFT) begin : g_tail
            logic unused_tail;
            assign unused_tail = ^SFFT_Out[NFFT-1:NUM_BINS];
        end
    endgenerate

    function automatic logic [W-1:0] mag_of(input logic [W-1:0] x);
        if (!x[W-1])
            return x;
        if (x == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
        return -x;
    endfunction

    assign xfer     = bin_valid && bin_ready;
    assign accept   = (state == IDLE) && OutputValid;
    assign busy_hit = (state != IDLE) && OutputValid;
    assign ptr_inc  = ptr + 1'b1;

    assign cur_mag = mag_of(bin_data);
    assign take    = cur_mag > run_mag;
    assign nxt_mag = take ? cur_mag : run_mag;
    assign nxt_idx = take ? bin_index : run_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (OutputValid) state_next = STREAM;
            STREAM:  if (xfer && bin_last) state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame storage needs no reset: it is always rewritten before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_BINS; i++)
                frame[i] <= SFFT_Out[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr            <= '0;
            bin_data       <= '0;
            bin_index      <= '0;
            bin_valid      <= 1'b0;
            bin_first      <= 1'b0;
            bin_last       <= 1'b0;
            run_mag        <= '0;
            run_idx        <= '0;
            peak_index     <= '0;
            peak_mag       <= '0;
            peak_valid     <= 1'b0;
            frames_dropped <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (busy_hit && frames_dropped != 16'hFFFF)
                frames_dropped <= frames_dropped + 16'd1;
            case (state)
                IDLE: begin
                    if (OutputValid) begin
                        ptr       <= '0;
                        bin_data  <= SFFT_Out[0];
                        bin_index <= '0;
                        bin_valid <= 1'b1;
                        bin_first <= 1'b1;
                        bin_last  <= 1'b0;
                        run_mag   <= '0;
                        run_idx   <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        run_mag <= nxt_mag;
                        run_idx <= nxt_idx;
                        if (bin_last) begin
                            bin_valid  <= 1'b0;
                            bin_first  <= 1'b0;
                            bin_last   <= 1'b0;
                            peak_index <= nxt_idx;
                            peak_mag   <= nxt_mag;
                            peak_valid <= 1'b1;
                        end else begin
                            ptr       <= ptr_inc;
                            bin_data  <= frame[ptr_inc];
                            bin_index <= IW'(ptr_inc);
                            bin_first <= 1'b0;
                            bin_last  <= (ptr_inc == AW'(NUM_BINS - 1));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfft_bin_streamer.sv
// Directed bench for sfft_bin_streamer: basic, backpressure, saturation,
// ties, drops, back-to-back frames and asynchronous reset mid-stream.
module tb_sfft_bin_streamer;

    localparam int NFFT = 8;
    localparam int NB   = 4;
    localparam int W    = 16;
    localparam int IW   = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NFFT-1:0][W-1:0] sfft_out;
    logic                   ov;
    logic [W-1:0]           bin_data;
    logic [IW-1:0]          bin_index;
    logic                   bin_valid;
    logic                   bin_ready;
    logic                   bin_first;
    logic                   bin_last;
    logic [IW-1:0]          peak_index;
    logic [W-1:0]           peak_mag;
    logic                   peak_valid;
    logic [15:0]            frames_dropped;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] fa [NB];
    logic [W-1:0] fb [NB];

    sfft_bin_streamer #(
        .NFFT(NFFT), .NUM_BINS(NB), .W(W), .IW(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .SFFT_Out(sfft_out),
        .OutputValid(ov),
        .bin_data(bin_data),
        .bin_index(bin_index),
        .bin_valid(bin_valid),
        .bin_ready(bin_ready),
        .bin_first(bin_first),
        .bin_last(bin_last),
        .peak_index(peak_index),
        .peak_mag(peak_mag),
        .peak_valid(peak_valid),
        .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic load(input logic [W-1:0] f [NB]);
        for (int i = 0; i < NFFT; i++)
            sfft_out[i] = 16'h7777;
        for (int i = 0; i < NB; i++)
            sfft_out[i] = f[i];
    endtask

    task automatic start(input logic [W-1:0] f [NB]);
        load(f);
        ov = 1'b1;
        tick();
        ov = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, bin_valid, 0);
        chk({tag, "_first"}, bin_first, 0);
        chk({tag, "_last"}, bin_last, 0);
        chk({tag, "_data"}, bin_data, 0);
        chk({tag, "_index"}, bin_index, 0);
        chk({tag, "_pidx"}, peak_index, 0);
        chk({tag, "_pmag"}, peak_mag, 0);
        chk({tag, "_pvalid"}, peak_valid, 0);
        chk({tag, "_drops"}, frames_dropped, 0);
    endtask

    task automatic stream_check(input logic [W-1:0] f [NB], input bit bp,
                                input bit pulse_last, input int pidx,
                                input int pmag);
        int   beat = 0;
        int   cyc  = 0;
        logic r;
        while (beat < NB && cyc < 40) begin
            r = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            bin_ready = r;
            if (pulse_last && r && beat == NB - 1)
                ov = 1'b1;
            chk("beat_valid", bin_valid, 1);
            chk("beat_index", bin_index, beat);
            chk("beat_data", bin_data, f[beat]);
            chk("beat_first", bin_first, beat == 0);
            chk("beat_last", bin_last, beat == NB - 1);
            chk("peak_quiet", peak_valid, 0);
            tick();
            ov = 1'b0;
            if (r)
                beat++;
            cyc++;
        end
        chk("stream_done", beat, NB);
        chk("peak_valid", peak_valid, 1);
        chk("peak_index", peak_index, pidx);
        chk("peak_mag", peak_mag, pmag);
        chk("valid_after", bin_valid, 0);
    endtask

    initial begin
        reset     = 1'b1;
        ov        = 1'b0;
        bin_ready = 1'b0;
        sfft_out  = '0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        check_reset_outputs("idle");

        // basic frame, ready always high
        fa = '{16'd10, 16'hFFFD, 16'd25, 16'd7};
        bin_ready = 1'b1;
        start(fa);
        stream_check(fa, 1'b0, 1'b0, 2, 25);
        tick();
        chk("pulse_one_cycle", peak_valid, 0);
        chk("peak_hold_idx", peak_index, 2);
        chk("peak_hold_mag", peak_mag, 25);

        // backpressure pattern 1,0,0,1,...
        start(fa);
        stream_check(fa, 1'b1, 1'b0, 2, 25);
        tick();

        // most negative value saturates
        fb = '{16'd5, 16'h8000, 16'd100, 16'hFF9C};
        start(fb);
        stream_check(fb, 1'b0, 1'b0, 1, 32767);

        // tie goes to lowest index; started right after the peak cycle
        tick();
        fb = '{16'hFFF7, 16'd9, 16'd3, 16'd0};
        start(fb);
        stream_check(fb, 1'b0, 1'b0, 0, 9);

        // back-to-back: new frame the cycle after peak_valid
        tick();
        chk("b2b_idle_pv", peak_valid, 0);
        fb = '{16'd1, 16'd2, 16'hFFFB, 16'd4};
        start(fb);
        chk("b2b_valid", bin_valid, 1);
        chk("b2b_data0", bin_data, 1);
        stream_check(fb, 1'b0, 1'b0, 2, 5);
        tick();

        // drops under stall
        bin_ready = 1'b0;
        start(fa);
        fb = '{16'd111, 16'd222, 16'd333, 16'd444};
        load(fb);
        ov = 1'b1;
        tick();
        ov = 1'b0;
        tick();
        ov = 1'b1;
        tick();
        ov = 1'b0;
        chk("drops_two", frames_dropped, 2);
        chk("drop_keep_data", bin_data, 10);
        stream_check(fa, 1'b0, 1'b1, 2, 25);
        chk("drop_on_last", frames_dropped, 3);
        tick();
        chk("not_captured", bin_valid, 0);
        tick();
        chk("still_idle", bin_valid, 0);

        // asynchronous reset at beat 2
        fb = '{16'd1, 16'd2, 16'd3, 16'd4};
        bin_ready = 1'b1;
        start(fb);
        tick();
        tick();
        chk("pre_rst_index", bin_index, 2);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        tick();
        check_reset_outputs("held");
        reset = 1'b0;
        tick();
        chk("post_rst_pv", peak_valid, 0);

        fb = '{16'hFFFF, 16'hFFFB, 16'd2, 16'd5};
        start(fb);
        stream_check(fb, 1'b0, 1'b0, 1, 5);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
